// File: rtl/forwarding_hazard_unit.sv
// Operand bypass select and load-use stall/bubble control for the pipelined RISC-V core.
// Optional performance counters are enabled with the HAZARD_PERF_CNT_EN macro.
module forwarding_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_id_i,
  input  logic [NUM_SRC-1:0]            src_used_id_i,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_ex_i,
  input  logic [REG_ADDR_W-1:0]         rd_ex_i,
  input  logic                          mem_read_ex_i,
  input  logic [REG_ADDR_W-1:0]         rd_mem_i,
  input  logic                          reg_write_mem_i,
  input  logic [REG_ADDR_W-1:0]         rd_wb_i,
  input  logic                          reg_write_wb_i,
  input  logic                          flush_i,
  output logic [2*NUM_SRC-1:0]          sel_o,
  output logic                          stall_o,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0]              stall_cnt_o,
  output logic [CNT_W-1:0]              fwd_cnt_o,
`endif
  output logic                          bubble_o
);

  localparam int CNT_LW = $clog2(LOAD_LAT + 1);

  typedef enum logic {
    IDLE,
    STALL
  } state_t;

  state_t              r_state;
  logic [CNT_LW-1:0]   r_cnt;
  logic [2*NUM_SRC-1:0] w_sel;
  logic                w_hit;
  logic                w_stall;

  // MEM result is younger than WB, so it wins when both match; x0 never forwards.
  always_comb begin
    w_sel = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (reg_write_mem_i && (rd_mem_i != '0) &&
          (rs_ex_i[k*REG_ADDR_W +: REG_ADDR_W] == rd_mem_i)) begin
        w_sel[2*k +: 2] = 2'b01;
      end else if (reg_write_wb_i && (rd_wb_i != '0) &&
                   (rs_ex_i[k*REG_ADDR_W +: REG_ADDR_W] == rd_wb_i)) begin
        w_sel[2*k +: 2] = 2'b10;
      end
    end
  end

  always_comb begin
    w_hit = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (src_used_id_i[k] && (rs_id_i[k*REG_ADDR_W +: REG_ADDR_W] == rd_ex_i)) begin
        w_hit = 1'b1;
      end
    end
    w_hit = w_hit && mem_read_ex_i && (rd_ex_i != '0);
  end

  // Outputs are gated by reset so they fall immediately when reset asserts.
  assign w_stall  = reset && !flush_i && ((r_state == STALL) || w_hit);
  assign stall_o  = w_stall;
  assign bubble_o = w_stall;
  assign sel_o    = reset ? w_sel : '0;

  // The first stall cycle is covered by the IDLE hit; STALL supplies the remaining LOAD_LAT-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else if (flush_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hit && (LOAD_LAT > 1)) begin
            r_state <= STALL;
            r_cnt   <= CNT_LW'(LOAD_LAT - 1);
          end
        end
        STALL: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_LW'(1)) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_fwd_cnt;

  // Both counters saturate at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if ((w_sel != '0) && (r_fwd_cnt != '1)) begin
        r_fwd_cnt <= r_fwd_cnt + 1'b1;
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign fwd_cnt_o   = r_fwd_cnt;
`endif

endmodule
